// File: rtl/frame_event_scheduler.sv
// frame_event_scheduler: turns count60 steps into frame/second strobes, queues
// clk5 events and releases them one per frame over a valid/ready handshake.
// Also raises a sticky stall flag when count60 stops advancing.
//
// Handshake: spawn_valid is raised only in OFFER and, once raised, it and
// spawn_id hold until spawn_valid & spawn_ready is seen on a rising clock edge.
// spawn_ready is ignored in every other state.
module frame_event_scheduler #(
    parameter int MAX_PENDING  = 7,
    parameter int ID_W         = 4,
    parameter int STALL_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      count60,
    input  logic            clk5,
    input  logic            spawn_ready,
    output logic            spawn_valid,
    output logic [ID_W-1:0] spawn_id,
    output logic            frame_tick,
    output logic            second_tick,
    output logic [5:0]      frame_num,
    output logic [2:0]      pending,
    output logic            overflow,
    output logic            stall_err,
    output logic [1:0]      fsm_state
);

    // Stall counter is wide enough to exceed STALL_CYCLES before saturating.
    localparam int SC_W = $clog2(STALL_CYCLES + 2);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        OFFER      = 2'd2
    } state_t;

    state_t          state_q;
    logic            spawn_valid_q;
    logic [ID_W-1:0] id_q;

    logic [5:0]      prev_count60_q;
    logic            frame_tick_q;
    logic            second_tick_q;
    logic [5:0]      frame_num_q;
    logic            clk5_d_q;

    logic [2:0]      pending_q, pending_d;
    logic            overflow_q, overflow_d;
    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            stall_err_q, stall_err_d;

    logic            count_change;
    logic            frame_new;
    logic            clk5_rise;
    logic            handshake;

    assign count_change = (count60 != prev_count60_q);
    // 60 is the brief wrap hold value and never counts as a frame.
    assign frame_new    = count_change && (count60 <= 6'd59);
    assign clk5_rise    = clk5 & ~clk5_d_q;
    assign handshake    = spawn_valid_q & spawn_ready;

    // Frame edge detection and clk5 edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_count60_q <= 6'd0;
            frame_tick_q   <= 1'b0;
            second_tick_q  <= 1'b0;
            frame_num_q    <= 6'd0;
            clk5_d_q       <= 1'b0;
        end else begin
            prev_count60_q <= count60;
            frame_tick_q   <= frame_new;
            second_tick_q  <= frame_new && (count60 == 6'd0);
            if (frame_new) begin
                frame_num_q <= count60;
            end
            clk5_d_q       <= clk5;
        end
    end

    // Pending count: a capture and a release in the same cycle cancel out.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (clk5_rise && !handshake) begin
            if (pending_q < 3'(MAX_PENDING)) begin
                pending_d = pending_q + 3'd1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (!clk5_rise && handshake) begin
            pending_d = pending_q - 3'd1;
        end
    end

    // Watchdog next state: clear on any count60 change, otherwise count up and hold at max.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (count_change) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + SC_W'(1);
        end
        stall_err_d = stall_err_q | (stall_cnt_q > SC_W'(STALL_CYCLES));
    end

    // Event queue and watchdog registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= 3'd0;
            overflow_q  <= 1'b0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    // Release FSM: every event waits for a fresh frame_tick, then is offered until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            spawn_valid_q <= 1'b0;
            id_q          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending_q != 3'd0) begin
                        state_q <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (frame_tick_q) begin
                        state_q       <= OFFER;
                        spawn_valid_q <= 1'b1;
                    end
                end
                OFFER: begin
                    if (spawn_ready) begin
                        state_q       <= IDLE;
                        spawn_valid_q <= 1'b0;
                        id_q          <= id_q + ID_W'(1);
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    spawn_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign spawn_id    = id_q;
    assign frame_tick  = frame_tick_q;
    assign second_tick = second_tick_q;
    assign frame_num   = frame_num_q;
    assign pending     = pending_q;
    assign overflow    = overflow_q;
    assign stall_err   = stall_err_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_frame_event_scheduler.sv
// Bench for frame_event_scheduler: directed phases followed by a random phase.
// Expected frame ticks and spawn ids go into queues; a negedge monitor pops
// and compares them while a reference model tracks pending/overflow/stall.
module tb_frame_event_scheduler;

  localparam int STALL = 50;
  localparam int MAXP  = 7;
  localparam int ID_W  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [5:0]      count60 = 6'd0;
  logic            clk5 = 1'b0;
  logic            spawn_ready = 1'b0;
  logic            spawn_valid;
  logic [ID_W-1:0] spawn_id;
  logic            frame_tick;
  logic            second_tick;
  logic [5:0]      frame_num;
  logic [2:0]      pending;
  logic            overflow;
  logic            stall_err;
  logic [1:0]      fsm_state;

  frame_event_scheduler #(
    .MAX_PENDING (MAXP),
    .ID_W        (ID_W),
    .STALL_CYCLES(STALL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .count60    (count60),
    .clk5       (clk5),
    .spawn_ready(spawn_ready),
    .spawn_valid(spawn_valid),
    .spawn_id   (spawn_id),
    .frame_tick (frame_tick),
    .second_tick(second_tick),
    .frame_num  (frame_num),
    .pending    (pending),
    .overflow   (overflow),
    .stall_err  (stall_err),
    .fsm_state  (fsm_state)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model state
  int              cyc = 0;
  logic [5:0]      m_prev = 6'd0;
  logic            m_clk5_prev = 1'b0;
  int              m_pending = 0;
  bit              m_overflow = 1'b0;
  int              m_stall_cnt = 0;
  bit              m_stall_err = 1'b0;
  logic [ID_W-1:0] m_next_id = '0;
  bit              m_rst_prev = 1'b1;
  logic [ID_W-1:0] id_q[$];
  logic [38:0]     exp_q[$];   // {cycle, second, frame}
  bit              prev_valid = 1'b0;
  bit              prev_ready = 1'b0;
  bit              prev_tick = 1'b0;
  logic [ID_W-1:0] prev_id = '0;
  int              hs_in_frame = 0;
  int              tick_total = 0;
  int              sec_total = 0;

  // scoreboard monitor: compare at negedge, then advance the model with the inputs
  always @(negedge clk) begin
    logic [38:0] e;
    bit          exp_tick;
    bit          hs;
    if (m_rst_prev) begin
      chk("rst_valid", spawn_valid, 0);
      chk("rst_id", spawn_id, 0);
      chk("rst_tick", frame_tick, 0);
      chk("rst_second", second_tick, 0);
      chk("rst_frame_num", frame_num, 0);
      chk("rst_state", fsm_state, 0);
    end
    chk("pending", pending, m_pending);
    chk("overflow", overflow, m_overflow);
    chk("stall_err", stall_err, m_stall_err);

    exp_tick = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      if (e[38:7] == 32'(cyc)) exp_tick = 1'b1;
    end
    chk("frame_tick", frame_tick, exp_tick);
    if (exp_tick) begin
      e = exp_q.pop_front();
      chk("second_tick", second_tick, e[6]);
      chk("frame_num", frame_num, e[5:0]);
    end else begin
      chk("second_tick_idle", second_tick, 0);
    end

    if (!m_rst_prev) begin
      if (spawn_valid && !prev_valid) chk("valid_after_tick", prev_tick, 1);
      if (prev_valid && !prev_ready) begin
        chk("valid_hold", spawn_valid, 1);
        chk("id_hold", spawn_id, prev_id);
      end
    end

    hs = spawn_valid && spawn_ready && !reset;
    if (hs) begin
      chk("hs_per_frame", hs_in_frame, 0);
      hs_in_frame++;
      if (id_q.size() == 0) chk("hs_unexpected", spawn_valid, 0);
      else chk("spawn_id", spawn_id, id_q.pop_front());
    end
    if (frame_tick) begin
      hs_in_frame = 0;
      tick_total++;
    end
    if (second_tick) sec_total++;

    prev_valid = spawn_valid;
    prev_ready = spawn_ready;
    prev_tick  = frame_tick;
    prev_id    = spawn_id;

    if (reset) begin
      m_prev      = 6'd0;
      m_clk5_prev = 1'b0;
      m_pending   = 0;
      m_overflow  = 1'b0;
      m_stall_cnt = 0;
      m_stall_err = 1'b0;
      m_next_id   = '0;
      hs_in_frame = 0;
      id_q.delete();
      exp_q.delete();
    end else begin
      m_stall_err = m_stall_err || (m_stall_cnt > STALL);
      if (count60 != m_prev) begin
        m_stall_cnt = 0;
        if (count60 <= 6'd59) exp_q.push_back({32'(cyc + 1), count60 == 6'd0, count60});
      end else begin
        m_stall_cnt++;
      end
      if (clk5 && !m_clk5_prev) begin
        if (hs || m_pending < MAXP) begin
          id_q.push_back(m_next_id);
          m_next_id++;
          if (!hs) m_pending++;
        end else begin
          m_overflow = 1'b1;
        end
      end else if (hs) begin
        m_pending--;
      end
      m_clk5_prev = clk5;
      m_prev      = count60;
    end
    m_rst_prev = reset;
    cyc++;
  end

  // driver
  int frame_len = 10;
  int frame_ctr = 0;
  int steps = 0;
  bit run_frames = 1'b0;
  bit rand_len = 1'b0;

  task automatic cycle();
    @(posedge clk);
    #1;
    if (run_frames) begin
      frame_ctr++;
      if (frame_ctr >= frame_len) begin
        frame_ctr = 0;
        count60 = (count60 >= 6'd60) ? 6'd0 : 6'(count60 + 6'd1);
        steps++;
        if (rand_len) frame_len = $urandom_range(3, 8);
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic pulse_clk5();
    clk5 = 1'b1;
    cycle();
    clk5 = 1'b0;
    cycle();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!spawn_valid && n < budget) begin
      cycle();
      n++;
    end
    chk(name, spawn_valid, 1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((pending != 3'd0 || id_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk(name, pending, 0);
    chk({name, "_ids"}, id_q.size(), 0);
  endtask

  initial begin
    int t0;
    int s0;
    do_reset(3);

    // frame sweep 0..59, 60, 0 at 10 cycles per value
    t0 = tick_total;
    s0 = sec_total;
    frame_len = 10;
    frame_ctr = 0;
    steps = 0;
    run_frames = 1'b1;
    while (steps < 61) cycle();
    run_frames = 1'b0;
    repeat (3) cycle();
    chk("t1_ticks", tick_total - t0, 60);
    chk("t1_seconds", sec_total - s0, 1);
    chk("t1_frame_num", frame_num, 0);

    // single event released on the next frame
    spawn_ready = 1'b1;
    clk5 = 1'b1;
    cycle();
    clk5 = 1'b0;
    chk("t2_pending", pending, 1);
    run_frames = 1'b1;
    wait_valid("t2_valid", 60);
    chk("t2_id", spawn_id, 0);
    wait_drain("t2_drain", 100);

    // wide clk5 pulse counts once
    spawn_ready = 1'b0;
    clk5 = 1'b1;
    repeat (20) cycle();
    clk5 = 1'b0;
    cycle();
    chk("t3_pending", pending, 1);
    spawn_ready = 1'b1;
    wait_drain("t3_drain", 100);

    // saturation and overflow, then drain one per frame
    do_reset(2);
    spawn_ready = 1'b0;
    repeat (9) pulse_clk5();
    chk("t4_pending", pending, 7);
    chk("t4_overflow", overflow, 1);
    spawn_ready = 1'b1;
    wait_drain("t4_drain", 600);

    // capture and release in the same cycle
    do_reset(2);
    spawn_ready = 1'b0;
    repeat (3) pulse_clk5();
    chk("t5_pending_pre", pending, 3);
    spawn_ready = 1'b1;
    wait_valid("t5_valid", 100);
    clk5 = 1'b1;
    cycle();
    clk5 = 1'b0;
    spawn_ready = 1'b0;
    chk("t5_pending", pending, 3);
    chk("t5_overflow", overflow, 0);

    // frozen timebase, then reset while offering
    run_frames = 1'b0;
    repeat (60) cycle();
    chk("t6_stall", stall_err, 1);
    run_frames = 1'b1;
    wait_valid("t6_valid", 60);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t6_valid_rst", spawn_valid, 0);
    chk("t6_pending_rst", pending, 0);
    chk("t6_stall_rst", stall_err, 0);
    chk("t6_overflow_rst", overflow, 0);

    // random traffic
    do_reset(2);
    rand_len = 1'b1;
    repeat (600) begin
      clk5 = ($urandom_range(0, 9) == 0) ? 1'b1 : (clk5 && ($urandom_range(0, 1) == 1));
      spawn_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    clk5 = 1'b0;
    spawn_ready = 1'b1;
    wait_drain("rand_drain", 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
